// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: FSM states,
// Cin source selects and flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_t;

  localparam logic [1:0] CIN_ZERO = 2'd0;
  localparam logic [1:0] CIN_ONE  = 2'd1;
  localparam logic [1:0] CIN_FLAG = 2'd2;

  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_Z = 0;

  // Select 3 is reserved and behaves as a zero carry-in.
  function automatic logic cin_select(input logic [1:0] sel, input logic c_flag);
    case (sel)
      CIN_ZERO: cin_select = 1'b0;
      CIN_ONE:  cin_select = 1'b1;
      CIN_FLAG: cin_select = c_flag;
      default:  cin_select = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 32 register file: two combinational read ports, a debug read port,
// one synchronous write port, R0 hardwired to zero, asynchronous clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREG = 8,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   rd_a,
  output logic [31:0]   rd_b,
  output logic [31:0]   dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd
);

  logic [31:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a     = (ra == '0)       ? '0 : regs[ra];
  assign rd_b     = (rb == '0)       ? '0 : regs[rb];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Sequential issue/writeback wrapper around an external combinational ALU:
// latches operands, holds them for EXEC_CYCLES, captures result and flags.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int unsigned NREG        = 8,
  parameter int unsigned EXEC_CYCLES = 1,
  localparam int unsigned AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [3:0]    cmd_op,
  input  logic          cmd_m,
  input  logic [1:0]    cmd_cin_sel,
  input  logic          cmd_imm_en,
  input  logic [31:0]   cmd_imm,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  output logic [31:0]   alu_opA,
  output logic [31:0]   alu_opB,
  output logic [3:0]    alu_S,
  output logic          alu_M,
  output logic          alu_Cin,
  input  logic [31:0]   alu_DO,
  input  logic          alu_C,
  input  logic          alu_V,
  input  logic          alu_N,
  input  logic          alu_Z,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [31:0]   wb_data,
  output logic [3:0]    flags_q,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] rd_q;
  logic [3:0]    res_flags;
  logic          res_alu;
  logic [31:0]   rf_a;
  logic [31:0]   rf_b;

  alu_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (cmd_ra),
    .rb       (cmd_rb),
    .dbg_addr (dbg_addr),
    .rd_a     (rf_a),
    .rd_b     (rf_b),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .wa       (wb_rd),
    .wd       (wb_data)
  );

  // wb_valid is high exactly while in ST_WB, so it doubles as the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      cnt       <= '0;
      rd_q      <= '0;
      res_flags <= '0;
      res_alu   <= 1'b0;
      alu_opA   <= '0;
      alu_opB   <= '0;
      alu_S     <= '0;
      alu_M     <= 1'b0;
      alu_Cin   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      flags_q   <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_load) begin
              wb_data  <= cmd_imm;
              wb_rd    <= cmd_rd;
              wb_valid <= 1'b1;
              res_alu  <= 1'b0;
              state    <= ST_WB;
            end else begin
              alu_opA <= rf_a;
              alu_opB <= cmd_imm_en ? cmd_imm : rf_b;
              alu_S   <= cmd_op;
              alu_M   <= cmd_m;
              alu_Cin <= cin_select(cmd_cin_sel, flags_q[FLG_C]);
              rd_q    <= cmd_rd;
              cnt     <= 4'(EXEC_CYCLES - 1);
              state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            wb_data   <= alu_DO;
            wb_rd     <= rd_q;
            wb_valid  <= 1'b1;
            res_flags <= {alu_C, alu_V, alu_N, alu_Z};
            res_alu   <= 1'b1;
            state     <= ST_WB;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WB: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
          if (res_alu) begin
            flags_q[FLG_N] <= res_flags[FLG_N];
            flags_q[FLG_Z] <= res_flags[FLG_Z];
            // Logic-mode ops leave carry/overflow untouched for chaining.
            if (!alu_M) begin
              flags_q[FLG_C] <= res_flags[FLG_C];
              flags_q[FLG_V] <= res_flags[FLG_V];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: bench-driven ALU stub, hand-computed
// expectations for loads, ALU ops, flag chaining, multicycle timing and reset.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        v3 = 1'b0;
  logic        cmd_load = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic        cmd_m = 1'b0;
  logic [1:0]  cmd_cin_sel = '0;
  logic        cmd_imm_en = 1'b0;
  logic [31:0] cmd_imm = '0;
  logic [2:0]  cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
  logic [31:0] alu_DO = '0;
  logic        alu_C = 1'b0, alu_V = 1'b0, alu_N = 1'b0, alu_Z = 1'b0;
  logic [2:0]  dbg_addr = '0;

  logic        cmd_ready, alu_M, alu_Cin, wb_valid;
  logic [31:0] alu_opA, alu_opB, wb_data, dbg_data;
  logic [3:0]  alu_S, flags_q;
  logic [2:0]  wb_rd;

  logic        ready3, alu_M3, alu_Cin3, wb_valid3;
  logic [31:0] alu_opA3, alu_opB3, wb_data3, dbg_data3;
  logic [3:0]  alu_S3, flags_q3;
  logic [2:0]  wb_rd3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_wb #(.NREG(8), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_m(cmd_m), .cmd_cin_sel(cmd_cin_sel),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rd(cmd_rd), .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S),
    .alu_M(alu_M), .alu_Cin(alu_Cin), .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V),
    .alu_N(alu_N), .alu_Z(alu_Z), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flags_q(flags_q), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_wb #(.NREG(8), .EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(ready3),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_m(cmd_m), .cmd_cin_sel(cmd_cin_sel),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rd(cmd_rd), .alu_opA(alu_opA3), .alu_opB(alu_opB3), .alu_S(alu_S3),
    .alu_M(alu_M3), .alu_Cin(alu_Cin3), .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V),
    .alu_N(alu_N), .alu_Z(alu_Z), .wb_valid(wb_valid3), .wb_rd(wb_rd3),
    .wb_data(wb_data3), .flags_q(flags_q3), .dbg_addr(dbg_addr), .dbg_data(dbg_data3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic stub(input logic [31:0] d, input logic [3:0] f);
    alu_DO = d;
    {alu_C, alu_V, alu_N, alu_Z} = f;
  endtask

  // Presents a command on dut and returns at the negedge after the accept edge.
  task automatic send(input logic ld, input logic [3:0] op, input logic m,
                      input logic [1:0] cs, input logic ie, input logic [31:0] imm,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    cmd_load = ld; cmd_op = op; cmd_m = m; cmd_cin_sel = cs;
    cmd_imm_en = ie; cmd_imm = imm; cmd_ra = a; cmd_rb = b; cmd_rd = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check("accept_wait", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic load_reg(input logic [2:0] d, input logic [31:0] val);
    send(1'b1, 4'd0, 1'b0, 2'd0, 1'b0, val, 3'd0, 3'd0, d);
    check("load_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("load_wb_rd", {29'd0, wb_rd}, {29'd0, d});
    check("load_wb_data", wb_data, val);
    @(negedge clk);
    check("load_wb_pulse", {31'd0, wb_valid}, 32'd0);
    dbg_addr = d;
    #1;
    check("load_readback", dbg_data, val);
  endtask

  // ALU op on dut (EXEC_CYCLES=1): returns at the negedge after flags commit.
  task automatic alu_op(input logic [3:0] op, input logic m, input logic [1:0] cs,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                        input logic exp_cin);
    send(1'b0, op, m, cs, 1'b0, 32'd0, a, b, d);
    check("op_cin", {31'd0, alu_Cin}, {31'd0, exp_cin});
    check("op_exec_no_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("op_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("op_wb_rd", {29'd0, wb_rd}, {29'd0, d});
    check("op_wb_data", wb_data, alu_DO);
    @(negedge clk);
    check("op_ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  logic rdy_log [24];
  logic wbv_log [24];
  int   first_acc;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_opA", alu_opA, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // EXEC_CYCLES=3 with cmd_valid held continuously: 5-cycle issue cadence
    stub(32'h0000_0055, 4'b0000);
    cmd_load = 1'b0; cmd_op = 4'd3; cmd_m = 1'b1; cmd_rd = 3'd1;
    v3 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rdy_log[i] = ready3;
      wbv_log[i] = wb_valid3;
      @(negedge clk);
    end
    v3 = 1'b0;
    first_acc = -1;
    for (int i = 0; i < 4; i++) if (first_acc < 0 && rdy_log[i]) first_acc = i;
    check("x3_first_accept_found", {31'd0, first_acc >= 0}, 32'd1);
    if (first_acc >= 0) begin
      for (int k = 0; k < 2; k++) begin
        int t;
        t = first_acc + 5 * k;
        for (int j = 1; j <= 4; j++)
          check("x3_ready_low", {31'd0, rdy_log[t + j]}, 32'd0);
        check("x3_next_accept", {31'd0, rdy_log[t + 5]}, 32'd1);
        check("x3_no_early_wb", {31'd0, wbv_log[t + 3]}, 32'd0);
        check("x3_wb_at_t4", {31'd0, wbv_log[t + 4]}, 32'd1);
      end
    end
    repeat (6) @(negedge clk);

    // Loads: flags must stay zero
    load_reg(3'd1, 32'h1234_1234);
    check("load_flags", {28'd0, flags_q}, 32'd0);
    load_reg(3'd2, 32'h8153_2657);
    check("load_flags2", {28'd0, flags_q}, 32'd0);
    dbg_addr = 3'd1; #1;
    check("r1_still", dbg_data, 32'h1234_1234);

    // Basic ALU op with operand hold through EXEC
    stub(32'h9387_3891, 4'b0110);
    send(1'b0, 4'b1001, 1'b0, 2'd1, 1'b0, 32'd0, 3'd1, 3'd2, 3'd3);
    check("op1_opA", alu_opA, 32'h1234_1234);
    check("op1_opB", alu_opB, 32'h8153_2657);
    check("op1_S", {28'd0, alu_S}, 32'd9);
    check("op1_M", {31'd0, alu_M}, 32'd0);
    check("op1_Cin", {31'd0, alu_Cin}, 32'd1);
    @(negedge clk);
    check("op1_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("op1_wb_data", wb_data, 32'h9387_3891);
    check("op1_opA_held", alu_opA, 32'h1234_1234);
    check("op1_opB_held", alu_opB, 32'h8153_2657);
    @(negedge clk);
    dbg_addr = 3'd3; #1;
    check("op1_r3", dbg_data, 32'h9387_3891);
    check("op1_flags", {28'd0, flags_q}, 32'h6);

    // Immediate operand B
    stub(32'h0000_00aa, 4'b0110);
    send(1'b0, 4'd6, 1'b0, 2'd3, 1'b1, 32'hcafe_0001, 3'd2, 3'd1, 3'd6);
    check("imm_opB", alu_opB, 32'hcafe_0001);
    check("imm_opA", alu_opA, 32'h8153_2657);
    check("imm_cin_reserved", {31'd0, alu_Cin}, 32'd0);
    repeat (2) @(negedge clk);

    // Carry chain
    stub(32'h0000_0001, 4'b1100);
    alu_op(4'd9, 1'b0, 2'd0, 3'd1, 3'd2, 3'd4, 1'b0);
    check("chain1_flags", {28'd0, flags_q}, 32'hc);
    alu_op(4'd9, 1'b0, 2'd2, 3'd1, 3'd2, 3'd5, 1'b1);
    check("chain2_flags", {28'd0, flags_q}, 32'hc);
    stub(32'h0000_0000, 4'b0001);
    alu_op(4'd6, 1'b1, 2'd0, 3'd1, 3'd2, 3'd6, 1'b0);
    check("logic_flags_hold_cv", {28'd0, flags_q}, 32'hd);

    // Destination R0: write suppressed, flags still update
    stub(32'hffff_ffff, 4'b0010);
    alu_op(4'd9, 1'b0, 2'd0, 3'd1, 3'd2, 3'd0, 1'b0);
    dbg_addr = 3'd0; #1;
    check("r0_zero", dbg_data, 32'd0);
    check("r0_flags", {28'd0, flags_q}, 32'h2);

    // Reset during EXEC of a write to R5
    load_reg(3'd5, 32'h00ad_a00a);
    stub(32'hdead_beef, 4'b1111);
    send(1'b0, 4'd9, 1'b0, 2'd0, 1'b0, 32'd0, 3'd1, 3'd2, 3'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec_no_wb", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_exec_no_wb2", {31'd0, wb_valid}, 32'd0);
    check("rst_exec_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_exec_flags", {28'd0, flags_q}, 32'd0);
    dbg_addr = 3'd5; #1;
    check("rst_exec_r5", dbg_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
